// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
// Player-input and DIP-switch front end between hps_io and a game core.
//  - Captures DIP banks (ioctl index 254) and a per-title mode byte (index 1).
//  - Conditions each player's directions: SOCD cancel, then an 8/4/2-way
//    restriction selected by mode[1:0].
//  - Registers buttons and shapes coin pulses to a minimum frame length.
// Optional build macro: ARCADE_INPUT_COIN_SHAPE_EN.
//  - Defined: each coin pulse is stretched to COIN_FRAMES vblank frames.
//  - Undefined: coin is joy[8] registered with one cycle of latency.
// Every output is registered in the clk_sys domain.
module arcade_input_mapper #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         DIP_BANKS   = 8,
  parameter logic [7:0] DIP_RESET   = 8'hFF,
  parameter int         COIN_FRAMES = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ioctl_wr,
  input  logic [7:0]               ioctl_index,
  input  logic [26:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic                     vblank,
  input  logic [16*NUM_PLAYERS-1:0] joy,
  output logic [8*DIP_BANKS-1:0]   dip,
  output logic [7:0]               mode,
  output logic [4*NUM_PLAYERS-1:0] dirs,
  output logic [4*NUM_PLAYERS-1:0] btns,
  output logic [NUM_PLAYERS-1:0]   coin
);

  localparam logic [7:0] IDX_DIP   = 8'd254;
  localparam logic [7:0] IDX_MODE  = 8'd1;
  localparam logic [3:0] COIN_LOAD = 4'(COIN_FRAMES);

  // Which axis a 4-way player is locked to when both axes are held.
  typedef enum logic {
    AXIS_V = 1'b0,
    AXIS_H = 1'b1
  } axis_e;

  // Address bits above the DIP window are never decoded.
  logic unused_addr;
  assign unused_addr = ^ioctl_addr[26:25];

  // ---------------------------------------------------------------------
  // DIP banks and mode byte
  // ---------------------------------------------------------------------
  logic [8*DIP_BANKS-1:0] dip_q, dip_d;
  logic [7:0]             mode_q, mode_d;
  logic                   dip_hit;

  // A DIP write must target index 254 with the upper window address zero;
  // the bank loop below drops bank numbers at or above DIP_BANKS.
  assign dip_hit = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == 22'd0);

  // Next-state for DIP banks and mode byte from the ioctl stream.
  always_comb begin
    dip_d  = dip_q;
    mode_d = mode_q;
    for (int b = 0; b < DIP_BANKS; b++) begin
      if (dip_hit && (ioctl_addr[2:0] == 3'(b))) begin
        dip_d[8*b +: 8] = ioctl_dout;
      end
    end
    if (ioctl_wr && (ioctl_index == IDX_MODE)) begin
      mode_d = ioctl_dout;
    end
  end

  // DIP and mode registers; DIPs reset to DIP_RESET, mode to 0.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dip_q  <= {DIP_BANKS{DIP_RESET}};
      mode_q <= 8'd0;
    end else begin
      dip_q  <= dip_d;
      mode_q <= mode_d;
    end
  end

  assign dip  = dip_q;
  assign mode = mode_q;

  // ---------------------------------------------------------------------
  // Frame tick (only needed by the coin shaper)
  // ---------------------------------------------------------------------
`ifdef ARCADE_INPUT_COIN_SHAPE_EN
  logic vblank_q;
  logic vb_tick;

  // Single-register edge detector on vblank; the tick is combinational, so
  // the counter moves on the clock edge that first samples vblank high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= vblank;
    end
  end

  assign vb_tick = vblank && !vblank_q;
`else
  logic unused_frame;
  assign unused_frame = vblank ^ (^COIN_LOAD);
`endif

  // ---------------------------------------------------------------------
  // Per-player conditioning
  // ---------------------------------------------------------------------
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0] raw;      // {up, down, left, right}
    logic [3:0] socd;
    logic [3:0] prev_q;   // previous post-SOCD sample, for edge detection
    logic [3:0] dir_d, dir_q;
    logic [3:0] btn_q;
    logic       v_rise, h_rise;
    axis_e      axis_q, axis_d;
    logic       coin_raw;
    logic       coin_d, coin_q;
    logic       unused_joy_hi;

    assign raw           = joy[16*p +: 4];
    assign coin_raw      = joy[16*p + 8];
    assign unused_joy_hi = ^joy[16*p + 9 +: 7];

    // SOCD cancel: opposite directions held together cancel each other.
    always_comb begin
      socd = raw;
      if (raw[3] && raw[2]) socd[3:2] = 2'b00;
      if (raw[1] && raw[0]) socd[1:0] = 2'b00;
    end

    assign v_rise = |(socd[3:2] & ~prev_q[3:2]);
    assign h_rise = |(socd[1:0] & ~prev_q[1:0]);

    // Axis next-state: the most recently pressed axis wins, vertical on a tie.
    always_comb begin
      axis_d = axis_q;
      if (v_rise) begin
        axis_d = AXIS_V;
      end else if (h_rise) begin
        axis_d = AXIS_H;
      end
    end

    // Restriction by mode[1:0]; 4-way uses this cycle's axis decision so a
    // newly pressed direction takes over on the same registered output.
    always_comb begin
      dir_d = socd;
      case (mode_q[1:0])
        2'd0: dir_d = socd;
        2'd1: begin
          if ((|socd[3:2]) && (|socd[1:0])) begin
            if (axis_d == AXIS_V) dir_d[1:0] = 2'b00;
            else                  dir_d[3:2] = 2'b00;
          end
        end
        2'd2:    dir_d[1:0] = 2'b00;
        default: dir_d[3:2] = 2'b00;
      endcase
    end

    // Direction, axis, edge history and button registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        prev_q <= 4'd0;
        axis_q <= AXIS_V;
        dir_q  <= 4'd0;
        btn_q  <= 4'd0;
      end else begin
        prev_q <= socd;
        axis_q <= axis_d;
        dir_q  <= dir_d;
        btn_q  <= joy[16*p + 4 +: 4];
      end
    end

`ifdef ARCADE_INPUT_COIN_SHAPE_EN
    logic       coin_prev_q;
    logic [3:0] cnt_q, cnt_d;
    logic       coin_edge;

    assign coin_edge = coin_raw && !coin_prev_q;

    // Coin shaper: an accepted edge loads the frame count (a coincident
    // frame tick is dropped); ticks count down to zero. New edges are taken
    // only while the output is low, and a held input keeps the output high.
    always_comb begin
      cnt_d = cnt_q;
      if (coin_edge && !coin_q) begin
        cnt_d = COIN_LOAD;
      end else if (vb_tick && (cnt_q != 4'd0)) begin
        cnt_d = cnt_q - 4'd1;
      end
      coin_d = (cnt_d != 4'd0) || coin_raw;
    end

    // Coin counter and input history registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        coin_prev_q <= 1'b0;
        cnt_q       <= 4'd0;
      end else begin
        coin_prev_q <= coin_raw;
        cnt_q       <= cnt_d;
      end
    end
`else
    // Without shaping the coin input is simply registered.
    always_comb begin
      coin_d = coin_raw;
    end
`endif

    // Coin output register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        coin_q <= 1'b0;
      end else begin
        coin_q <= coin_d;
      end
    end

    assign dirs[4*p +: 4] = dir_q;
    assign btns[4*p +: 4] = btn_q;
    assign coin[p]        = coin_q;
  end

endmodule
